// File: rtl/sar_busqueda.sv
// sar_busqueda: successive-approximation search controller, plus the
// combinational comparador it is normally paired with.

// comparador: magnitude compare of A against the trial value B.
module comparador #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             menor,
  output logic             igual,
  output logic             mayor
);
  assign menor = (A < B);
  assign igual = (A == B);
  assign mayor = (A > B);
endmodule

// sar_busqueda: binary-searches the comparator's A by driving trial values
// on B, MSB first; one trial bit is decided per PRUEBA cycle.
module sar_busqueda #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             menor,
  input  logic             igual,
  input  logic             mayor,
  output logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado
);
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PRUEBA, FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [WIDTH-1:0] r_res, w_res_nxt;
  logic [IDXW-1:0]  r_idx, w_idx_nxt;
  logic [WIDTH-1:0] w_trial;
  logic [IDXW-1:0]  w_idx_dec;

  // mayor carries no information beyond "not menor and not igual": keeping
  // the bit is the default, so it is intentionally unused.
  logic w_unused;
  assign w_unused = mayor;

  // State and datapath registers; reset abandons any search in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_b     <= '0;
      r_res   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_b     <= w_b_nxt;
      r_res   <= w_res_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state and trial update; flag priority is igual > menor > keep.
  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    w_res_nxt   = r_res;
    w_idx_nxt   = r_idx;
    w_idx_dec   = r_idx - 1'b1;
    w_trial     = r_b;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_b_nxt              = '0;
          w_b_nxt[WIDTH-1]     = 1'b1;
          w_idx_nxt            = IDXW'(WIDTH - 1);
          w_state_nxt          = PRUEBA;
        end
      end
      PRUEBA: begin
        if (igual) begin
          w_res_nxt   = r_b;
          w_state_nxt = FIN;
        end else begin
          if (menor) w_trial[r_idx] = 1'b0;
          if (r_idx == '0) begin
            w_b_nxt     = w_trial;
            w_res_nxt   = w_trial;
            w_state_nxt = FIN;
          end else begin
            w_trial[w_idx_dec] = 1'b1;
            w_b_nxt            = w_trial;
            w_idx_nxt          = w_idx_dec;
          end
        end
      end
      FIN: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign B         = r_b;
  assign resultado = r_res;
  assign busy      = (r_state == PRUEBA);
  assign done      = (r_state == FIN);
endmodule

// File: tb/tb_sar_busqueda.sv
module tb_sar_busqueda;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] A, B, resultado;
  logic       busy, done;
  logic       c_menor, c_igual, c_mayor;
  logic       menor, igual, mayor;
  logic       ovr;
  logic [2:0] ovr_flags;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  comparador #(.WIDTH(4)) u_cmp (.A(A), .B(B), .menor(c_menor), .igual(c_igual), .mayor(c_mayor));

  assign menor = ovr ? ovr_flags[2] : c_menor;
  assign igual = ovr ? ovr_flags[1] : c_igual;
  assign mayor = ovr ? ovr_flags[0] : c_mayor;

  sar_busqueda #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .menor(menor), .igual(igual), .mayor(mayor),
    .B(B), .busy(busy), .done(done), .resultado(resultado)
  );

  `define CHK(tag, obs, exp) \
    total++; \
    assert ((obs) === (exp)) passed++; \
    else $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_search(input logic [3:0] a, input int exp_n, input logic [3:0] exp_res);
    int n;
    A = a;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    total++;
    if (!busy) passed++;
    else $error("FAIL wait expired: busy still high after %0d cycles", n);
    `CHK("busy_cycles", n, exp_n)
    `CHK("done_high", done, 1'b1)
    `CHK("resultado", resultado, exp_res)
    step();
    `CHK("done_one_cycle", done, 1'b0)
  endtask

  function automatic int model_n(input logic [3:0] a);
    int n = 4;
    for (int b = 3; b >= 0; b--) if (a[b]) n = 4 - b;
    return n;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; A = 4'h0; ovr = 1'b0; ovr_flags = 3'b000;
    step(); step();
    reset = 1'b0;
    total++;
    if (B === 4'h0 && busy === 1'b0 && done === 1'b0 && resultado === 4'h0) passed++;
    else $error("FAIL reset state: B=%0h busy=%0b done=%0b resultado=%0h", B, busy, done, resultado);
    `CHK("rst_B", B, 4'h0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_res", resultado, 4'h0)

    A = 4'b0111; start = 1'b1;
    step(); start = 1'b0;
    `CHK("s7_B0", B, 4'b1000) `CHK("s7_busy0", busy, 1'b1)
    step(); `CHK("s7_B1", B, 4'b0100) `CHK("s7_busy1", busy, 1'b1)
    step(); `CHK("s7_B2", B, 4'b0110) `CHK("s7_busy2", busy, 1'b1)
    step(); `CHK("s7_B3", B, 4'b0111) `CHK("s7_busy3", busy, 1'b1)
    step();
    `CHK("s7_busy_end", busy, 1'b0) `CHK("s7_done", done, 1'b1)
    `CHK("s7_res", resultado, 4'b0111)
    step(); `CHK("s7_done_off", done, 1'b0)

    A = 4'b0000; start = 1'b1;
    step(); start = 1'b0;
    `CHK("s0_B0", B, 4'b1000)
    step(); `CHK("s0_B1", B, 4'b0100)
    step(); `CHK("s0_B2", B, 4'b0010)
    step(); `CHK("s0_B3", B, 4'b0001) `CHK("s0_busy3", busy, 1'b1)
    step(); `CHK("s0_done", done, 1'b1) `CHK("s0_res", resultado, 4'b0000)
    step();

    do_search(4'b1000, 1, 4'b1000);

    A = 4'b1111; start = 1'b1;
    step(); start = 1'b0;
    step(); start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    `CHK("ff_done", done, 1'b1) `CHK("ff_res", resultado, 4'b1111)
    step(); `CHK("ff_idle_busy", busy, 1'b0)
    A = 4'b1010;
    step(); step();
    `CHK("ff_no_requeue", busy, 1'b0)
    `CHK("ff_res_held", resultado, 4'b1111)
    do_search(4'b1010, 3, 4'b1010);

    A = 4'b0101; start = 1'b1;
    step(); start = 1'b0;
    step();
    `CHK("rm_busy", busy, 1'b1) `CHK("rm_B", B, 4'b0100)
    reset = 1'b1;
    step();
    reset = 1'b0;
    `CHK("rm_B0", B, 4'h0) `CHK("rm_busy0", busy, 1'b0)
    `CHK("rm_done0", done, 1'b0) `CHK("rm_res0", resultado, 4'h0)
    do_search(4'b0101, 4, 4'b0101);

    ovr = 1'b1; ovr_flags = 3'b000;
    do_search(4'h3, 4, 4'b1111);
    ovr_flags = 3'b111;
    do_search(4'h3, 1, 4'b1000);
    ovr_flags = 3'b100;
    do_search(4'h3, 4, 4'b0000);
    ovr = 1'b0;

    for (int a = 0; a < 16; a++) do_search(4'(a), model_n(4'(a)), 4'(a));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
